i2c_reg_access_ctrl: RTL and testbench

- Sequences register-file access for the sensor I2C slave on the system clock domain.
- Takes byte-level events from the slave controller (address match, received byte, transmit request, start/stop) and implements register-pointer protocol with auto-increment.
- Arbitrates the shared register file between the I2C side and the local sensor write port.
- Sits between the I2C slave core (events pre-synchronised to clk as 1-cycle pulses) and the sensor acquisition logic.

---
 rtl/i2c_reg_access_ctrl_pkg.sv | 17 +
 rtl/i2c_reg_access_ctrl_if.sv | 36 +++
 rtl/i2c_reg_access_ctrl_regfile.sv | 27 ++
 rtl/i2c_reg_access_ctrl.sv | 107 ++++++++++
 tb/tb_i2c_reg_access_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_reg_access_ctrl_pkg.sv
// Shared types and constants for the I2C register access controller.
package i2c_reg_pkg;

    localparam int NREG_DEF = 16;
    localparam int AW_DEF   = 4;

    // Byte returned when the master reads outside a read transfer.
    localparam logic [7:0] IDLE_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PTR,
        WRITE,
        READ
    } state_e;

endpackage

// File: rtl/i2c_reg_access_ctrl_if.sv
// Byte-event bus from the I2C slave core plus the sensor write port.
interface i2c_reg_access_ctrl_if #(
    parameter int AW = 4
);
    logic          i2c_start;
    logic          i2c_stop;
    logic          i2c_addr_match;
    logic          i2c_rw;
    logic          i2c_rx_valid;
    logic [7:0]    i2c_rx_data;
    logic          i2c_tx_req;
    logic [7:0]    i2c_tx_data;
    logic          i2c_tx_valid;
    logic          sns_req;
    logic [AW-1:0] sns_addr;
    logic [7:0]    sns_wdata;
    logic          sns_ack;
    logic          busy;

    // Controller side.
    modport slave (
        input  i2c_start, i2c_stop, i2c_addr_match, i2c_rw,
        input  i2c_rx_valid, i2c_rx_data, i2c_tx_req,
        input  sns_req, sns_addr, sns_wdata,
        output i2c_tx_data, i2c_tx_valid, sns_ack, busy
    );

    // Slave core / sensor side driving the controller.
    modport master (
        output i2c_start, i2c_stop, i2c_addr_match, i2c_rw,
        output i2c_rx_valid, i2c_rx_data, i2c_tx_req,
        output sns_req, sns_addr, sns_wdata,
        input  i2c_tx_data, i2c_tx_valid, sns_ack, busy
    );

endinterface

// File: rtl/i2c_reg_access_ctrl_regfile.sv
// NREG x 8 register storage: one write port (arbitrated upstream), one async read port.
module sensor_regfile #(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [NREG-1:0][7:0] mem_q;

    // Storage update; reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_reg_access_ctrl.sv
// Register-pointer protocol FSM for an I2C slave, with auto-increment and
// arbitration of the shared register file against the sensor write port.
module i2c_reg_access_ctrl
    import i2c_reg_pkg::*;
#(
    parameter int              NREG         = NREG_DEF,
    parameter int              AW           = AW_DEF,
    parameter logic [NREG-1:0] RO_MASK      = NREG'(16'h000F),
    parameter bit              LOCK_ON_READ = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    i2c_reg_access_ctrl_if.slave bus
);
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          sns_ack_q;
    logic          i2c_we, tx_from_reg, sns_grant;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [7:0]    rf_wdata, rf_rdata;

    // State, pointer and transmit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            sns_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            sns_ack_q  <= sns_grant;
        end
    end

    // Next state / pointer: stop > start > addr_match > byte events.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        i2c_we      = 1'b0;
        tx_from_reg = 1'b0;
        if (bus.i2c_stop || bus.i2c_start) begin
            state_d = IDLE;
        end else if (bus.i2c_addr_match) begin
            // Also reached from non-IDLE states: acts as an implicit restart.
            state_d = bus.i2c_rw ? READ : WAIT_PTR;
        end else begin
            case (state_q)
                WAIT_PTR: if (bus.i2c_rx_valid) begin
                    ptr_d   = bus.i2c_rx_data[AW-1:0];
                    state_d = WRITE;
                end
                WRITE: if (bus.i2c_rx_valid) begin
                    // Read-only registers drop the byte but still advance.
                    i2c_we = ~RO_MASK[ptr_q];
                    ptr_d  = ptr_q + 1'b1;
                end
                READ: if (bus.i2c_tx_req) begin
                    tx_from_reg = 1'b1;
                    ptr_d       = ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every tx_req is answered next cycle so the slave core never stalls.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        if (bus.i2c_tx_req) begin
            tx_valid_d = 1'b1;
            tx_data_d  = tx_from_reg ? rf_rdata : IDLE_FILL;
        end
    end

    // Register-file write mux: I2C wins, sensor waits; reads can lock the sensor out.
    always_comb begin
        sns_grant = bus.sns_req && !sns_ack_q && !i2c_we &&
                    !(LOCK_ON_READ && (state_q == READ));
        rf_we     = i2c_we || sns_grant;
        rf_waddr  = i2c_we ? ptr_q : bus.sns_addr;
        rf_wdata  = i2c_we ? bus.i2c_rx_data : bus.sns_wdata;
    end

    sensor_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .raddr_i (ptr_q),
        .rdata_o (rf_rdata)
    );

    assign bus.i2c_tx_data  = tx_data_q;
    assign bus.i2c_tx_valid = tx_valid_q;
    assign bus.sns_ack      = sns_ack_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// Scoreboard bench: transmit requests push expected bytes, a monitor thread
// pops and compares on every tx_valid; direct checks cover control outputs.
module tb_i2c_reg_access_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t sbq[$];

    i2c_reg_access_ctrl_if #(.AW(4)) bus ();

    i2c_reg_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic p_start();
        bus.i2c_start = 1'b1; tick(); bus.i2c_start = 1'b0;
    endtask

    task automatic p_stop();
        bus.i2c_stop = 1'b1; tick(); bus.i2c_stop = 1'b0;
    endtask

    task automatic p_match(input logic rw);
        bus.i2c_addr_match = 1'b1; bus.i2c_rw = rw; tick();
        bus.i2c_addr_match = 1'b0; bus.i2c_rw = 1'b0;
    endtask

    task automatic p_rx(input logic [7:0] b);
        bus.i2c_rx_valid = 1'b1; bus.i2c_rx_data = b; tick();
        bus.i2c_rx_valid = 1'b0;
    endtask

    task automatic p_tx(input logic [7:0] exp);
        exp_t e;
        e.d = exp;
        e.c = cyc;
        sbq.push_back(e);
        bus.i2c_tx_req = 1'b1; tick(); bus.i2c_tx_req = 1'b0;
    endtask

    task automatic sns_wr(input logic [3:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        bus.sns_req = 1'b1; bus.sns_addr = a; bus.sns_wdata = d;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.sns_ack) begin got = 1'b1; break; end
        end
        bus.sns_req = 1'b0;
        chk("sns_ack_seen", {7'd0, got}, 8'd1);
    endtask

    initial begin
        logic got;
        cyc = 0; checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.i2c_start = 0; bus.i2c_stop = 0; bus.i2c_addr_match = 0; bus.i2c_rw = 0;
        bus.i2c_rx_valid = 0; bus.i2c_rx_data = 0; bus.i2c_tx_req = 0;
        bus.sns_req = 0; bus.sns_addr = 0; bus.sns_wdata = 0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && bus.i2c_tx_valid === 1'b1) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL tx_unexpected actual=%h expected=none", bus.i2c_tx_data);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        if (bus.i2c_tx_data !== e.d || cyc != e.c + 1) begin
                            failures++;
                            $display("FAIL tx_data actual=%h@%0d expected=%h@%0d",
                                     bus.i2c_tx_data, cyc, e.d, e.c + 1);
                        end
                    end
                end
            end
        join_none

        // Reset values.
        tick(); tick();
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_tx_valid", {7'd0, bus.i2c_tx_valid}, 8'd0);
        chk("rst_sns_ack", {7'd0, bus.sns_ack}, 8'd0);
        chk("rst_tx_data", bus.i2c_tx_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // Write burst 5 <- A1, 6 <- A2, pointer ends at 7.
        p_start(); p_match(1'b0);
        chk("wr_busy", {7'd0, bus.busy}, 8'd1);
        p_rx(8'h05); p_rx(8'hA1); p_rx(8'hA2);
        chk("wr_busy_hold", {7'd0, bus.busy}, 8'd1);
        p_stop();
        chk("stop_idle", {7'd0, bus.busy}, 8'd0);
        sns_wr(4'd7, 8'h3C);
        p_start(); p_match(1'b1); p_tx(8'h3C); p_stop();
        p_start(); p_match(1'b0); p_rx(8'h05); p_start(); p_match(1'b1);
        p_tx(8'hA1); p_tx(8'hA2); p_stop();
        // Pointer upper bits ignored: F6 -> 6.
        p_start(); p_match(1'b0); p_rx(8'hF6); p_start(); p_match(1'b1);
        p_tx(8'hA2); p_stop();

        // Read-only protection on register 2; sensor can still write it.
        sns_wr(4'd2, 8'hC2); sns_wr(4'd3, 8'h33);
        p_start(); p_match(1'b0); p_rx(8'h02); p_rx(8'h55); p_stop();
        p_start(); p_match(1'b1); p_tx(8'h33); p_stop();
        p_start(); p_match(1'b0); p_rx(8'h02); p_start(); p_match(1'b1);
        p_tx(8'hC2); p_tx(8'h33); p_stop();

        // Combined read across the wrap.
        sns_wr(4'd15, 8'hF5); sns_wr(4'd0, 8'h0A); sns_wr(4'd1, 8'h1B);
        p_start(); p_match(1'b0); p_rx(8'h0F); p_start(); p_match(1'b1);
        p_tx(8'hF5); p_tx(8'h0A); p_tx(8'h1B); p_stop();

        // Fill byte outside READ.
        p_tx(8'hFF);
        p_start(); p_match(1'b0); p_tx(8'hFF); p_stop();

        // Stop beats a same-cycle addr_match.
        bus.i2c_stop = 1'b1; bus.i2c_addr_match = 1'b1; tick();
        bus.i2c_stop = 1'b0; bus.i2c_addr_match = 1'b0;
        chk("prio_stop", {7'd0, bus.busy}, 8'd0);

        // Same-cycle I2C write and sensor write to register 6.
        p_start(); p_match(1'b0); p_rx(8'h06);
        bus.i2c_rx_valid = 1'b1; bus.i2c_rx_data = 8'h11;
        bus.sns_req = 1'b1; bus.sns_addr = 4'd6; bus.sns_wdata = 8'h77;
        tick();
        bus.i2c_rx_valid = 1'b0;
        chk("arb_stall", {7'd0, bus.sns_ack}, 8'd0);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.sns_ack) begin got = 1'b1; break; end
        end
        bus.sns_req = 1'b0;
        chk("arb_ack", {7'd0, got}, 8'd1);
        p_stop();
        p_start(); p_match(1'b0); p_rx(8'h06); p_start(); p_match(1'b1);
        p_tx(8'h77); p_stop();

        // Sensor locked out during a read burst until stop returns to IDLE.
        p_start(); p_match(1'b1);
        bus.sns_req = 1'b1; bus.sns_addr = 4'd9; bus.sns_wdata = 8'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lock_hold", {7'd0, bus.sns_ack}, 8'd0);
        end
        bus.i2c_stop = 1'b1; tick(); bus.i2c_stop = 1'b0;
        chk("lock_after_stop", {7'd0, bus.sns_ack}, 8'd0);
        tick();
        chk("lock_ack", {7'd0, bus.sns_ack}, 8'd1);
        bus.sns_req = 1'b0;
        p_start(); p_match(1'b0); p_rx(8'h09); p_start(); p_match(1'b1);
        p_tx(8'h99); p_stop();

        // Reset in the middle of a write.
        p_start(); p_match(1'b0); p_rx(8'h05);
        rst_n = 1'b0;
        #2;
        chk("mrst_busy", {7'd0, bus.busy}, 8'd0);
        chk("mrst_tx_valid", {7'd0, bus.i2c_tx_valid}, 8'd0);
        chk("mrst_sns_ack", {7'd0, bus.sns_ack}, 8'd0);
        chk("mrst_tx_data", bus.i2c_tx_data, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        p_tx(8'hFF);
        p_start(); p_match(1'b1); p_tx(8'h00); p_tx(8'h00); p_stop();

        tick(); tick(); tick();
        chk("sb_drain", 8'(sbq.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
